instr_encoder_loader: RTL

//  Encoder counterpart of the main control decoder: packs symbolic instruction requests
//  (kind + fields) into 32-bit extended-MIPS words and writes them sequentially into

---
 rtl/instr_encoder_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction requests into 32-bit extended-MIPS words and writes them to imem.
// Latency 1 cycle from accepted request to imem write; 1 word/cycle sustained.
// in_ready is high only in RUN; FILL (NOP flush) and FULL (terminal) refuse requests.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [25:0] in_imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        full,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_count
);

  // Count must reach DEPTH itself, hence DEPTH+1 codes.
  localparam int unsigned CW = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [3:0] K_RTYPE  = 4'd0;
  localparam logic [3:0] K_JMXOR  = 4'd1;
  localparam logic [3:0] K_BALRV  = 4'd2;
  localparam logic [3:0] K_BALN   = 4'd3;
  localparam logic [3:0] K_JSP    = 4'd4;
  localparam logic [3:0] K_BGEZAL = 4'd5;
  localparam logic [3:0] K_ORI    = 4'd6;
  localparam logic [3:0] K_LW     = 4'd7;
  localparam logic [3:0] K_SW     = 4'd8;
  localparam logic [3:0] K_BEQ    = 4'd9;
  localparam logic [3:0] K_FLUSH  = 4'd15;

  logic [1:0]    state;
  logic [CW-1:0] count;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        is_flush;
  logic        accept;
  logic        do_write;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;

  logic [15:0] imm16;
  assign imm16 = in_imm[15:0];

  assign in_ready = (state == S_RUN);
  assign accept   = in_valid && in_ready;

  // Encode the request; reject forms the decoder would read back as a different instruction.
  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    is_flush = 1'b0;
    case (in_kind)
      K_RTYPE: begin
        enc_word = {6'd0, in_rs, in_rt, in_rd, in_shamt, in_funct};
        // funct 34 with rd=0 aliases jmxor; funct 22 is reserved for balrv.
        enc_err  = ((in_funct == 6'd34) && (in_rd == 5'd0)) || (in_funct == 6'd22);
      end
      K_JMXOR:  enc_word = {6'd0, in_rs, in_rt, 5'd0, 5'd0, 6'd34};
      K_BALRV:  enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd22};
      K_BALN:   enc_word = {6'd27, in_imm};
      K_JSP:    enc_word = {6'd18, in_imm};
      K_BGEZAL: enc_word = {6'd35, in_rs, 5'd0, imm16};
      K_ORI:    enc_word = {6'd13, in_rs, in_rt, imm16};
      K_LW: begin
        enc_word = {6'd35, in_rs, in_rt, imm16};
        // lw with rt=0 shares its encoding with bgezal.
        enc_err  = (in_rt == 5'd0);
      end
      K_SW:     enc_word = {6'd43, in_rs, in_rt, imm16};
      K_BEQ:    enc_word = {6'd4, in_rs, in_rt, imm16};
      K_FLUSH:  is_flush = 1'b1;
      default:  enc_err  = 1'b1;
    endcase
  end

  // A word goes out either for a good non-flush request or for each FILL cycle (NOP).
  always_comb begin
    do_write = ((state == S_RUN) && accept && !enc_err && !is_flush) || (state == S_FILL);
    wr_data  = (state == S_FILL) ? 32'h0 : enc_word;
    wr_addr  = BASE_ADDR + (32'(count) << 2);
  end

  // Control: FSM, word count, status flags and error accounting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_RUN;
      count     <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= 1'b0;
      if (accept && enc_err) begin
        err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (accept && is_flush && !enc_err) begin
        state <= S_FILL;
        busy  <= 1'b1;
      end
      if (do_write) begin
        count <= count + CW'(1);
        if (count == LAST_IDX) begin
          state <= S_FULL;
          full  <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Registered imem write port; address and data hold between strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
    end else begin
      imem_we <= do_write;
      if (do_write) begin
        imem_addr  <= wr_addr;
        imem_wdata <= wr_data;
      end
    end
  end

endmodule
